data_memory_banked: RTL



---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 38 +++
 rtl/data_memory_banked.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the banked line-wide data memory.
//   dmem_state_e : controller state encoding (2 bits)
//   CNT_W        : width of the wait-latency counter
//   idx_shift()  : number of byte-offset bits in an address for a given line width
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } dmem_state_e;

  // Wide enough for the largest supported LATENCY (15).
  localparam int CNT_W = 4;

  // Byte-offset bits: line index = byte address >> idx_shift(LINE_W).
  function automatic int unsigned idx_shift(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port line storage with per-byte write enables.
//   clk   : clock, all activity on the rising edge
//   en    : access enable for this cycle
//   wen   : per-byte write enables (bit k covers wdata[8k+7:8k]); all-zero = read
//   addr  : line index
//   wdata : write line data
//   rdata : registered read line (contents before any same-cycle write)
// Contents are not reset.
module dmem_array #(
  parameter int LINE_W = 256,
  parameter int DEPTH  = 512
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic [LINE_W/8-1:0]        wen,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [LINE_W-1:0]          wdata,
  output logic [LINE_W-1:0]          rdata
);

  localparam int BYTES = LINE_W / 8;

  logic [LINE_W-1:0] mem [DEPTH];

  // All enabled bytes land on the same edge, so a line is never left
  // half-written by a single request.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < BYTES; k++) begin
        if (wen[k]) begin
          mem[addr][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_banked.sv
// Line-wide, fixed-latency main memory behind the L1 data cache.
// Each accepted request (address, line data, byte mask, write flag) is
// latched, so the requester may change its outputs right after acceptance.
//
// Handshake: enable_i is sampled only while the controller is idle
// (busy_o = 0); the rising edge that sees enable_i = 1 in IDLE accepts the
// request and raises busy_o. While busy_o = 1, enable_i is ignored and
// nothing is queued. Completion is a one-cycle ack_o pulse, with err_o valid
// in the same cycle and, for an in-range read, data_o updated in that cycle
// and held until the next read completion. busy_o is low in the ack cycle,
// so a request held on enable_i is accepted at the edge ending that cycle.
//
// Ports:
//   clk_i    : clock
//   rst_i    : asynchronous active-low reset
//   addr_i   : byte address (offset bits inside a line are ignored)
//   data_i   : write line data
//   mask_i   : byte write enables
//   enable_i : request valid
//   write_i  : 1 = write, 0 = read
//   busy_o   : request in flight
//   ack_o    : completion pulse
//   err_o    : line index >= DEPTH, valid with ack_o
//   data_o   : read line
//   state_o  : controller state, for observation
module data_memory_banked
  import dmem_pkg::*;
#(
  parameter int LINE_W  = 256,  // multiple of 8, at least 16
  parameter int DEPTH   = 512,  // power of two, at least 2
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 6     // 1..15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [LINE_W-1:0]   data_i,
  input  logic [LINE_W/8-1:0] mask_i,
  input  logic                enable_i,
  input  logic                write_i,
  output logic                busy_o,
  output logic                ack_o,
  output logic                err_o,
  output logic [LINE_W-1:0]   data_o,
  output dmem_state_e         state_o
);

  localparam int BYTES  = LINE_W / 8;
  localparam int SHIFT  = idx_shift(LINE_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LIDX_W = ADDR_W - SHIFT;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [LIDX_W-1:0] lidx_q;
  logic [LINE_W-1:0] wdata_q;
  logic [BYTES-1:0]  mask_q;
  logic              write_q;
  logic              err_q;
  logic              idx_err;

  logic              arr_en;
  logic [BYTES-1:0]  arr_wen;
  logic [IDX_W-1:0]  arr_addr;
  logic [LINE_W-1:0] arr_rdata;

  // Offset bits inside a line never select anything.
  logic unused_offset;
  assign unused_offset = ^addr_i[SHIFT-1:0];

  assign state_o  = state_q;
  assign arr_addr = lidx_q[IDX_W-1:0];

  // Index bits above the array's address range only flag an error.
  generate
    if (LIDX_W > IDX_W) begin : g_upper
      assign idx_err = |lidx_q[LIDX_W-1:IDX_W];
    end else begin : g_no_upper
      assign idx_err = 1'b0;
    end
  endgenerate

  // An out-of-range request never touches the array.
  assign arr_en  = (state_q == ACCESS) && !idx_err;
  assign arr_wen = write_q ? mask_q : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i) state_d = WAIT;
      WAIT:    if (cnt_q == LAT_C) state_d = ACCESS;
      ACCESS:  state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The array access happens on the edge leaving ACCESS; its registered read
  // data is stable during ACK. The completion outputs are registered on the
  // edge leaving ACK, so ack_o/err_o/data_o appear together, LATENCY+2 edges
  // after acceptance, while the controller is already back in IDLE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lidx_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      busy_o  <= 1'b0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      data_o  <= '0;
    end else begin
      state_q <= state_d;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable_i) begin
            lidx_q  <= addr_i[ADDR_W-1:SHIFT];
            wdata_q <= data_i;
            mask_q  <= mask_i;
            write_q <= write_i;
            busy_o  <= 1'b1;
            cnt_q   <= CNT_W'(1);
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        ACCESS: begin
          err_q <= idx_err;
        end
        ACK: begin
          ack_o  <= 1'b1;
          err_o  <= err_q;
          busy_o <= 1'b0;
          cnt_q  <= '0;
          if (!write_q && !err_q) begin
            data_o <= arr_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  dmem_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk_i),
    .en    (arr_en),
    .wen   (arr_wen),
    .addr  (arr_addr),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

endmodule
